// File: rtl/ahb_subordinate_sram.sv
// AHB subordinate in front of a byte-lane SRAM: programmable wait states, two-cycle
// ERROR responses, and write->read forwarding for back-to-back beats to one word.
module ahb_subordinate_sram #(
  parameter int DATA_WDT    = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  logic [1:0]          i_htrans,
  input  logic                i_hwrite,
  input  logic [2:0]          i_hsize,
  input  logic [2:0]          i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output logic [1:0]          o_hresp
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic [IDX_W-1:0] idx_reg;
  logic write_reg;
  logic [3:0] lane_reg;
  logic [3:0] fwd_mask_reg;
  logic [DATA_WDT-1:0] fwd_data_reg;
  logic [DATA_WDT-1:0] hrdata_reg;
  logic [DATA_WDT-1:0] ram_rdata;
  logic [DATA_WDT-1:0] rd_word;

  logic addr_phase_open, accept, legal, accept_legal;
  logic wr_commit, rd_load, fwd_hit, rd_data_phase;
  logic [IDX_W-1:0] acc_idx;
  logic [3:0] acc_lanes;
  logic unused_hburst;

  assign unused_hburst = ^i_hburst;

  // Address phases are only sampled in cycles where this subordinate drives o_hready=1.
  assign addr_phase_open = (state_reg == S_IDLE) || (state_reg == S_DATA) || (state_reg == S_ERR2);
  assign accept          = addr_phase_open && i_hsel && i_hready && i_htrans[1];
  assign accept_legal    = accept && legal;
  assign acc_idx         = i_haddr[IDX_W+1:2];
  assign wr_commit       = (state_reg == S_DATA) && write_reg && i_hreset_n;
  assign rd_load         = accept_legal && !i_hwrite;
  assign fwd_hit         = wr_commit && rd_load && (acc_idx == idx_reg);
  assign rd_data_phase   = (state_reg == S_DATA) && !write_reg;

  always_comb begin
    acc_lanes = 4'b0000;
    legal     = (i_haddr[31:2] < 30'(MEM_DEPTH));
    case (i_hsize)
      3'd0: acc_lanes = 4'b0001 << i_haddr[1:0];
      3'd1: begin
        acc_lanes = i_haddr[1] ? 4'b1100 : 4'b0011;
        if (i_haddr[0]) legal = 1'b0;
      end
      3'd2: begin
        acc_lanes = 4'b1111;
        if (i_haddr[1:0] != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    o_hready      = 1'b1;
    o_hresp       = 2'b00;
    case (state_reg)
      S_WAIT: begin
        o_hready = 1'b0;
        if (wait_cnt_reg == 4'd0) state_next = S_DATA;
        else wait_cnt_next = wait_cnt_reg - 4'd1;
      end
      S_ERR1: begin
        o_hready   = 1'b0;
        o_hresp    = 2'b01;
        state_next = S_ERR2;
      end
      S_ERR2:  o_hresp = 2'b01;
      default: ;
    endcase
    if (addr_phase_open) begin
      if (accept_legal) begin
        if (WAIT_STATES > 0) begin
          state_next    = S_WAIT;
          wait_cnt_next = WAIT_LOAD;
        end else begin
          state_next = S_DATA;
        end
      end else if (accept) begin
        state_next = S_ERR1;
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hreset_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      hrdata_reg   <= '0;
      idx_reg      <= '0;
      write_reg    <= 1'b0;
      lane_reg     <= 4'b0000;
      fwd_mask_reg <= 4'b0000;
      fwd_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (rd_data_phase) hrdata_reg <= rd_word;
      if (accept_legal) begin
        idx_reg      <= acc_idx;
        write_reg    <= i_hwrite;
        lane_reg     <= acc_lanes;
        // Lanes the committing write touches override the pre-write SRAM read.
        fwd_mask_reg <= fwd_hit ? lane_reg : 4'b0000;
        fwd_data_reg <= i_hwdata;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge i_hclk) begin
        if (wr_commit && lane_reg[gi]) mem[idx_reg] <= i_hwdata[8*gi +: 8];
        if (rd_load) rd_reg <= mem[acc_idx];
      end

      assign ram_rdata[8*gi +: 8] = rd_reg;
      assign rd_word[8*gi +: 8]   = fwd_mask_reg[gi] ? fwd_data_reg[8*gi +: 8] : rd_reg;
    end
  endgenerate

  assign o_hrdata = rd_data_phase ? rd_word : hrdata_reg;

endmodule

// File: tb/tb_ahb_subordinate_sram.sv
// Bench for ahb_subordinate_sram: two instances (0 and 3 wait states) checked every cycle
// against a byte-addressed transfer-level model, plus directed literal checks.
module tb_ahb_subordinate_sram;

  localparam int DEPTH = 64;
  localparam int WS0   = 0;
  localparam int WS1   = 3;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        hsel[2];
  logic [31:0] haddr[2];
  logic [1:0]  htrans[2];
  logic        hwrite[2];
  logic [2:0]  hsize[2];
  logic [2:0]  hburst[2];
  logic [31:0] hwdata[2];
  logic [31:0] hrdata_o[2];
  logic        hready_o[2];
  logic [1:0]  hresp_o[2];

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // transfer-level model state
  logic [7:0]  mdl_mem [2][DEPTH*4];
  logic [31:0] mdl_last[2];
  bit          ph_act[2];
  int          ph_c[2], ph_last[2], ph_n[2];
  bit          ph_err[2], ph_wr[2], ph_rd[2];
  logic [31:0] ph_addr[2], ph_rdata[2];

  req_t req_q[$];
  int max_wait, err_cycles;

  always #5 clk = ~clk;

  ahb_subordinate_sram #(.DATA_WDT(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
    .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]), .i_hburst(hburst[0]),
    .i_hwdata(hwdata[0]), .i_hready(hready_o[0]), .o_hrdata(hrdata_o[0]),
    .o_hready(hready_o[0]), .o_hresp(hresp_o[0]));

  ahb_subordinate_sram #(.DATA_WDT(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
    .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]), .i_hburst(hburst[1]),
    .i_hwdata(hwdata[1]), .i_hready(hready_o[1]), .o_hrdata(hrdata_o[1]),
    .o_hready(hready_o[1]), .o_hresp(hresp_o[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  // Model: a data phase lasts ws+1 cycles (OKAY) or 2 cycles (ERROR); writes land at its end,
  // and a read snapshots memory after any write finishing on the same edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        chk_en      = 1;
        ph_act[k]   = 0;
        mdl_last[k] = 32'h0;
      end else begin
        bit can_acc;
        can_acc = !ph_act[k] || (ph_c[k] == ph_last[k]);
        if (ph_act[k]) begin
          if (ph_c[k] == ph_last[k]) begin
            if (ph_wr[k]) begin
              for (int i = 0; i < ph_n[k]; i++) begin
                int b;
                b = int'(ph_addr[k]) + i;
                mdl_mem[k][b] = hwdata[k][8*(b%4) +: 8];
              end
            end
            if (ph_rd[k]) mdl_last[k] = ph_rdata[k];
            ph_act[k] = 0;
          end else begin
            ph_c[k]++;
          end
        end
        if (can_acc && hsel[k] && htrans[k][1]) begin
          logic [31:0] a;
          bit lg;
          int w;
          a  = haddr[k];
          lg = ((a >> 2) < DEPTH) && (hsize[k] <= 3'd2) && ((a % (32'd1 << hsize[k])) == 0);
          ph_act[k]  = 1;
          ph_c[k]    = 0;
          ph_err[k]  = !lg;
          ph_last[k] = lg ? ws_of(k) : 1;
          ph_wr[k]   = lg && hwrite[k];
          ph_rd[k]   = lg && !hwrite[k];
          ph_addr[k] = a;
          ph_n[k]    = 1 << hsize[k];
          if (ph_rd[k]) begin
            w = int'(a >> 2);
            ph_rdata[k] = {mdl_mem[k][4*w+3], mdl_mem[k][4*w+2], mdl_mem[k][4*w+1], mdl_mem[k][4*w]};
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic e_rdy;
        logic [1:0] e_resp;
        logic [31:0] e_dat;
        e_rdy  = 1'b1;
        e_resp = 2'd0;
        e_dat  = mdl_last[k];
        if (ph_act[k]) begin
          e_rdy  = (ph_c[k] == ph_last[k]);
          e_resp = ph_err[k] ? 2'd1 : 2'd0;
          if (ph_rd[k] && e_rdy) e_dat = ph_rdata[k];
        end
        chk($sformatf("dut%0d_hready", k), 32'(hready_o[k]), 32'(e_rdy));
        chk($sformatf("dut%0d_hresp", k), 32'(hresp_o[k]), 32'(e_resp));
        chk($sformatf("dut%0d_hrdata", k), hrdata_o[k], e_dat);
      end
    end
  end

  task automatic push(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [31:0] wdata);
    req_t r;
    r.sel = 1'b1; r.trans = 2'd2; r.addr = addr; r.wr = wr; r.size = size; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  function automatic req_t rand_req();
    req_t r;
    int m, word;
    m = $urandom_range(0, 19);
    r.sel   = ($urandom_range(0, 9) != 0);
    r.trans = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    r.wr    = 1'($urandom_range(0, 1));
    r.wdata = $urandom();
    r.size  = 3'($urandom_range(0, 2));
    word    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
    r.addr  = 32'(word * 4);
    if (r.size == 3'd0 || $urandom_range(0, 3) == 0) r.addr = r.addr + 32'($urandom_range(0, 3));
    if (m == 0) r.addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 1023));
    if (m == 1) r.size = 3'($urandom_range(3, 7));
    if (m == 2) r.addr = $urandom();
    return r;
  endfunction

  // Pipelined manager: address of beat n overlaps the data phase of beat n-1.
  task automatic run_reqs(input int k);
    req_t cur, dph;
    bit dvalid;
    int waits;
    logic r;
    dvalid = 0;
    max_wait = 0;
    err_cycles = 0;
    while (req_q.size() > 0 || dvalid) begin
      if (req_q.size() > 0) begin
        cur = req_q[0];
        hsel[k] = cur.sel; htrans[k] = cur.trans; haddr[k] = cur.addr;
        hwrite[k] = cur.wr; hsize[k] = cur.size; hburst[k] = 3'($urandom_range(0, 7));
      end else begin
        hsel[k] = 1'b0; htrans[k] = 2'd0;
      end
      hwdata[k] = (dvalid && dph.wr) ? dph.wdata : $urandom();
      waits = 0;
      forever begin
        @(negedge clk);
        r = hready_o[k];
        if (hresp_o[k] == 2'd1) err_cycles++;
        @(posedge clk);
        #1;
        if (r) break;
        waits++;
        if (waits > 40) begin
          total++; bad++;
          $display("FAIL dut%0d_timeout: hready stuck low for %0d cycles, required release", k, waits);
          req_q.delete();
          break;
        end
      end
      if (waits > max_wait) max_wait = waits;
      dvalid = 0;
      if (req_q.size() > 0) begin
        dph = req_q.pop_front();
        dvalid = dph.sel && dph.trans[1];
        $display("dut%0d txn sel=%0d trans=%0d addr=%h wr=%0d size=%0d wdata=%h",
                 k, dph.sel, dph.trans, dph.addr, dph.wr, dph.size, dph.wdata);
      end
    end
    hsel[k] = 1'b0;
    htrans[k] = 2'd0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      hsel[k] = 0; haddr[k] = 0; htrans[k] = 0; hwrite[k] = 0;
      hsize[k] = 0; hburst[k] = 0; hwdata[k] = 0;
    end
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_hready", k), 32'(hready_o[k]), 32'd1);
      chk($sformatf("rst%0d_hresp", k), 32'(hresp_o[k]), 32'd0);
      chk($sformatf("rst%0d_hrdata", k), hrdata_o[k], 32'd0);
    end

    // known contents everywhere: word i = 0x10000000 + i
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) push(32'(4 * i), 1'b1, 3'd2, 32'h1000_0000 + 32'(i));
      run_reqs(k);
    end

    push(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
    push(32'h10, 1'b0, 3'd2, 32'h0);
    run_reqs(0);
    chk("fwd_w32_rdata", hrdata_o[0], 32'hDEADBEEF);
    chk("fwd_w32_model", mdl_last[0], 32'hDEADBEEF);
    chk("fwd_w32_waits", 32'(max_wait), 32'd0);

    push(32'h20, 1'b1, 3'd2, 32'h0000_0000);
    push(32'h21, 1'b1, 3'd0, 32'hAAAA_AAAA);
    push(32'h22, 1'b1, 3'd1, 32'h5555_5555);
    push(32'h20, 1'b0, 3'd2, 32'h0);
    run_reqs(0);
    chk("byte_lanes_rdata", hrdata_o[0], 32'h5555_AA00);
    chk("byte_lanes_model", mdl_last[0], 32'h5555_AA00);

    push(32'(4 * DEPTH), 1'b0, 3'd2, 32'h0);
    run_reqs(0);
    chk("err_range_cycles", 32'(err_cycles), 32'd2);
    push(32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF);
    run_reqs(0);
    chk("err_align_cycles", 32'(err_cycles), 32'd2);
    push(32'h0, 1'b0, 3'd2, 32'h0);
    run_reqs(0);
    chk("err_align_mem", hrdata_o[0], 32'h1000_0000);

    push(32'h4, 1'b0, 3'd2, 32'h0);
    run_reqs(1);
    chk("ws3_waits", 32'(max_wait), 32'd3);
    chk("ws3_rdata", hrdata_o[1], 32'h1000_0001);

    // reset while a write to 0x30 sits in its wait states
    hsel[1] = 1; htrans[1] = 2'd2; haddr[1] = 32'h30; hwrite[1] = 1; hsize[1] = 3'd2;
    @(posedge clk);
    #1;
    hsel[1] = 0; htrans[1] = 2'd0; hwdata[1] = 32'hBADC0FFE;
    @(posedge clk);
    #1;
    chk("mid_wait_hready", 32'(hready_o[1]), 32'd0);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    chk("mid_rst_hready", 32'(hready_o[1]), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    push(32'h30, 1'b0, 3'd2, 32'h0);
    run_reqs(1);
    chk("mid_rst_mem", hrdata_o[1], 32'h1000_000C);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) req_q.push_back(rand_req());
      run_reqs(k);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
